// File: rtl/imem_line_fill.sv
// imem_line_fill: instruction-side line-fill engine.
// Takes one I_CACHE miss at a time and reads the four words of the 16-byte line
// from a 32-bit word memory, one outstanding request at a time. It then returns
// the assembled 128-bit line together with a one-cycle ready pulse.
// Optional feature macro: IMEM_CRITICAL_WORD_FIRST_EN. When it is defined, the
// missed word is fetched first and the remaining words follow with wrap-around.
// When it is undefined, the words are always fetched in order 0,1,2,3.
// Every output comes straight from a flop.
module imem_line_fill #(
   parameter int LINE_WORDS = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         imem_read_start,
   input  logic [31:0]  imemory_address_bus1,
   output logic [127:0] imemory_data_bus1,
   output logic         imem_read_rdy,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   input  logic         mem_gnt,
   input  logic         mem_rvalid,
   input  logic [31:0]  mem_rdata
);

   // The engine is built around a 4-word, 2-bit-indexed line.
   if (LINE_WORDS != 4) begin : g_bad_line_words
      $error("imem_line_fill: LINE_WORDS must be 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [27:0]   line_base_q, line_base_d;
   logic [1:0]    beat_q, beat_d;
   logic [1:0]    word_idx_q, word_idx_d;
   logic [127:0]  line_q, line_d;
   logic          rdy_q, rdy_d;
   logic          mem_req_q, mem_req_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic          slot_we;
   logic [1:0]    start_idx;
   logic          unused_addr_bits;

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
   // The missed word goes out first.
   assign start_idx        = imemory_address_bus1[3:2];
   assign unused_addr_bits = ^imemory_address_bus1[1:0];
`else
   // Fixed ascending order. The word offset of the miss does not matter.
   assign start_idx        = 2'd0;
   assign unused_addr_bits = ^imemory_address_bus1[3:0];
`endif

   // Next-state, next-output and next-counter logic for the fill sequencer.
   always_comb begin
      state_d     = state_q;
      line_base_d = line_base_q;
      beat_d      = beat_q;
      word_idx_d  = word_idx_q;
      rdy_d       = 1'b0;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      slot_we     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (imem_read_start) begin
               line_base_d = imemory_address_bus1[31:4];
               beat_d      = 2'd0;
               word_idx_d  = start_idx;
               mem_req_d   = 1'b1;
               mem_addr_d  = {imemory_address_bus1[31:4], start_idx, 2'b00};
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // Request and address are held unchanged until the memory accepts them.
            // A stray rvalid seen in this state is ignored.
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               slot_we = 1'b1;
               if (beat_q == 2'd3) begin
                  rdy_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  beat_d     = beat_q + 2'd1;
                  word_idx_d = word_idx_q + 2'd1;
                  mem_req_d  = 1'b1;
                  // The index wraps within the 2-bit field, so it never carries into line_base.
                  mem_addr_d = {line_base_q, word_idx_q + 2'd1, 2'b00};
                  state_d    = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Each returned word is written only into its own slot.
   // Slots that are not written keep the last completed line.
   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
      assign line_d[32*gi +: 32] = (slot_we && (word_idx_q == 2'(gi)))
                                   ? mem_rdata : line_q[32*gi +: 32];
   end

   // State register for the sequencer, the line buffer and the registered outputs.
   // Reset is synchronous and active-low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         line_base_q <= '0;
         beat_q      <= '0;
         word_idx_q  <= '0;
         line_q      <= '0;
         rdy_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         line_base_q <= line_base_d;
         beat_q      <= beat_d;
         word_idx_q  <= word_idx_d;
         line_q      <= line_d;
         rdy_q       <= rdy_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign imemory_data_bus1 = line_q;
   assign imem_read_rdy     = rdy_q;
   assign mem_req           = mem_req_q;
   assign mem_addr          = mem_addr_q;

endmodule

// File: tb/tb_imem_line_fill.sv
// Directed bench for imem_line_fill.
// The bench models a word memory that returns addr ^ 0xA5A5_0000. The grant
// delay per beat can be set, and rvalid is returned one cycle after the grant.
// Expected request orders follow IMEM_CRITICAL_WORD_FIRST_EN.
`timescale 1ns/1ps
module tb_imem_line_fill;

   logic         clk = 1'b0;
   logic         reset;
   logic         imem_read_start;
   logic [31:0]  imemory_address_bus1;
   logic [127:0] imemory_data_bus1;
   logic         imem_read_rdy;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_gnt;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;

   always #5 clk = ~clk;

   imem_line_fill #(.LINE_WORDS(4)) dut (
      .clk                  (clk),
      .reset                (reset),
      .imem_read_start      (imem_read_start),
      .imemory_address_bus1 (imemory_address_bus1),
      .imemory_data_bus1    (imemory_data_bus1),
      .imem_read_rdy        (imem_read_rdy),
      .mem_req              (mem_req),
      .mem_addr             (mem_addr),
      .mem_gnt              (mem_gnt),
      .mem_rvalid           (mem_rvalid),
      .mem_rdata            (mem_rdata)
   );

   // Expected lines, written out by hand.
   localparam logic [127:0] LINE_1000 = 128'hA5A5100C_A5A51008_A5A51004_A5A51000;
   localparam logic [127:0] LINE_2000 = 128'hA5A5200C_A5A52008_A5A52004_A5A52000;
   localparam logic [127:0] LINE_3000 = 128'hA5A5300C_A5A53008_A5A53004_A5A53000;

   // Expected mem_addr order. Element [0] is the first request.
`ifdef IMEM_CRITICAL_WORD_FIRST_EN
   localparam logic [3:0][31:0] ORD_1008 = {32'h1004, 32'h1000, 32'h100C, 32'h1008};
   localparam logic [3:0][31:0] ORD_3004 = {32'h3000, 32'h300C, 32'h3008, 32'h3004};
`else
   localparam logic [3:0][31:0] ORD_1008 = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
   localparam logic [3:0][31:0] ORD_3004 = {32'h300C, 32'h3008, 32'h3004, 32'h3000};
`endif
   localparam logic [3:0][31:0] ORD_2000 = {32'h200C, 32'h2008, 32'h2004, 32'h2000};

   int vec_cnt     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Runs one fill. The start is sampled in cycle 0, and cyc counts the cycles after it.
   // stall_beat/stall_len: the grant for that beat is held back for stall_len cycles.
   // inject_rv: rvalid with junk data is driven during every stalled REQ cycle.
   // hold_start: imem_read_start stays high for the whole fill.
   // abort_beat: once this beat is granted, reset is asserted in the next cycle.
   task automatic do_fill(input string name, input logic [31:0] addr,
                          input logic [3:0][31:0] exp_addrs,
                          input int stall_beat, input int stall_len,
                          input bit inject_rv, input bit hold_start,
                          input int abort_beat, input int exp_rdy,
                          input logic [127:0] exp_line);
      int beat = 0;
      int stall = 0;
      int rv_cyc = -1;
      int n_req = 0;
      int rdy_cyc = -1;
      int rdy_cnt = 0;
      int stable_bad = 0;
      int overlap = 0;
      bit outstanding = 1'b0;
      bit req_open = 1'b0;
      bit abort_next = 1'b0;
      bit aborted = 1'b0;
      logic [31:0]  held_addr = '0;
      logic [127:0] line_seen = '0;
      @(negedge clk);
      imemory_address_bus1 = addr;
      imem_read_start = 1'b1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (!hold_start) imem_read_start = 1'b0;
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata = '0;
         if (abort_next) begin
            reset = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (imem_read_rdy) begin
            rdy_cnt++;
            if (rdy_cyc < 0) begin
               rdy_cyc = cyc;
               line_seen = imemory_data_bus1;
            end
         end
         if (rdy_cyc >= 0 && cyc > rdy_cyc) break;
         if (mem_req && outstanding) overlap++;
         if (cyc == rv_cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata = held_addr ^ 32'hA5A5_0000;
            outstanding = 1'b0;
         end
         if (mem_req && beat < 4) begin
            if (!req_open) begin
               req_open = 1'b1;
               held_addr = mem_addr;
               chk({name, "/addr"}, 128'(mem_addr), 128'(exp_addrs[beat]));
            end else if (mem_addr !== held_addr) begin
               stable_bad++;
            end
            if (stall >= ((beat == stall_beat) ? stall_len : 0)) begin
               mem_gnt = 1'b1;
               req_open = 1'b0;
               stall = 0;
               outstanding = 1'b1;
               rv_cyc = cyc + 1;
               n_req++;
               if (beat == abort_beat) abort_next = 1'b1;
               beat++;
            end else begin
               stall++;
               if (inject_rv) begin
                  mem_rvalid = 1'b1;
                  mem_rdata = 32'hBAD0_0000 | 32'(cyc);
               end
            end
         end else if (mem_req) begin
            n_req++;
         end
      end
      if (!aborted) begin
         chk({name, "/rdy_cycle"}, 128'(rdy_cyc), 128'(exp_rdy));
         chk({name, "/line"}, line_seen, exp_line);
         chk({name, "/num_requests"}, 128'(n_req), 128'(4));
         chk({name, "/rdy_pulses"}, 128'(rdy_cnt), 128'(1));
         chk({name, "/addr_unstable"}, 128'(stable_bad), 128'(0));
         chk({name, "/req_while_outstanding"}, 128'(overlap), 128'(0));
      end
   endtask

   initial begin
      // Reset is held for 3 cycles while start is high.
      reset = 1'b0;
      imem_read_start = 1'b1;
      imemory_address_bus1 = 32'h0000_1008;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset/mem_req", 128'(mem_req), 128'(0));
         chk("reset/rdy", 128'(imem_read_rdy), 128'(0));
         chk("reset/line", imemory_data_bus1, 128'(0));
      end
      chk("reset/mem_addr", 128'(mem_addr), 128'(0));
      reset = 1'b1;
      imem_read_start = 1'b0;
      @(negedge clk);
      chk("reset/no_fill", 128'(mem_req), 128'(0));

      // Basic fill with no stalls. The expected order depends on the macro.
      do_fill("basic", 32'h0000_1008, ORD_1008, -1, 0, 1'b0, 1'b0, -1, 9, LINE_1000);

      // The grant for beat 1 is delayed by 3 cycles.
      do_fill("backpressure", 32'h0000_1008, ORD_1008, 1, 3, 1'b0, 1'b0, -1, 12, LINE_1000);

      // Reset after beat 2 is granted. Its rvalid then arrives in IDLE.
      do_fill("abort", 32'h0000_1008, ORD_1008, -1, 0, 1'b0, 1'b0, 2, 0, '0);
      @(negedge clk);
      reset = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      chk("abort/mem_req_after_reset", 128'(mem_req), 128'(0));
      chk("abort/rdy_after_reset", 128'(imem_read_rdy), 128'(0));
      chk("abort/line_after_reset", imemory_data_bus1, 128'(0));
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      chk("abort/mem_req_after_stray", 128'(mem_req), 128'(0));
      chk("abort/line_after_stray", imemory_data_bus1, 128'(0));
      do_fill("refill", 32'h0000_2000, ORD_2000, -1, 0, 1'b0, 1'b0, -1, 9, LINE_2000);

      // Start is held high throughout, and rvalid is injected while in REQ.
      do_fill("robust", 32'h0000_3004, ORD_3004, 0, 2, 1'b1, 1'b1, -1, 11, LINE_3000);
      chk("robust/idle_after_done", 128'(mem_req), 128'(0));
      @(negedge clk);
      chk("robust/second_fill_req", 128'(mem_req), 128'(1));
      chk("robust/second_fill_addr", 128'(mem_addr), 128'(ORD_3004[0]));
      imem_read_start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("robust/mem_req_after_reset", 128'(mem_req), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_line_fill.md
# imem_line_fill

- Instruction-side line-fill engine between the CPU's I_CACHE miss port and a 32-bit word memory.
- Services one cache-line miss at a time: takes a 32-bit miss address, reads the 4 words of the 16-byte line one request at a time, and returns the assembled 128-bit line with a one-cycle ready pulse.
- Sits directly downstream of the fetch stage's instruction cache.
- Drives the `imemory_*` / `imem_*` signals the CPU exposes.

## Interface
Parameters:
- `LINE_WORDS`, 4, words per line; fixed at 4. Any other value is a compile-time error.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: active-low, synchronous reset, sampled on the `clk` rising edge.
- `imem_read_start` in 1: fill request from I_CACHE; acted on only in IDLE.
- `imemory_address_bus1` in 32: byte address of the miss. Bits [3:2] give the requested word; bits [1:0] are ignored.
- `imemory_data_bus1` out 128: assembled line. Word k sits in bits [32k+31:32k].
- `imem_read_rdy` out 1: one-cycle pulse; the line is valid.
- `mem_req` out 1: word read request to the backing memory.
- `mem_addr` out 32: word-aligned read address.
- `mem_gnt` in 1: backing memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid. Arrives at least 1 cycle after its `mem_gnt`.
- `mem_rdata` in 32: read data word.

## Operation
States: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - If `imem_read_start`=1: latch `line_base`=addr[31:4] and `first_idx`=addr[3:2]. Clear the beat counter (2 bits). Go to REQ.
- **REQ**
  - `mem_req`=1.
  - `mem_addr`={line_base, word_idx, 2'b00}.
  - Both outputs are held stable until `mem_gnt`=1, then go to WAIT.
  - `mem_rvalid` seen in REQ is ignored.
- **WAIT**
  - `mem_req`=0.
  - On `mem_rvalid`=1: write `mem_rdata` into line slot `word_idx`.
    - If beat==3, go to DONE.
    - Otherwise beat++, `word_idx`=(word_idx+1) mod 4, go to REQ.
- **DONE**
  - `imem_read_rdy`=1 for exactly this cycle, then go to IDLE.
- At most one memory request is outstanding at any time.
- `imem_read_start` is ignored in REQ, WAIT and DONE.
- The requester must drop `imem_read_start` in the cycle `imem_read_rdy`=1. If start is still 1 in the next IDLE cycle, a new fill begins.
- The line register is written only on accepted rvalid beats.
  - `imemory_data_bus1` holds the last completed line until the next fill overwrites its slots.
  - Consumers sample it only while `imem_read_rdy`=1.
- Word index arithmetic is 2-bit and wraps 3→0. The line base never changes within a fill, so no carry goes into bit 4.

## Timing
- Reset (`reset`=0 at a rising edge):
  - state=IDLE
  - `imem_read_rdy`=0, `mem_req`=0, `mem_addr`=0
  - `imemory_data_bus1`=0, beat=0, word_idx=0
- Reset mid-fill abandons the fill immediately. Any later `mem_rvalid` from the abandoned request is ignored, because it arrives in IDLE.
- Best case, with `mem_gnt` in the same cycle as `mem_req` and `mem_rvalid` one cycle later:
  - start sampled in cycle 0
  - beats occupy cycles 1–8, two cycles per beat
  - `imem_read_rdy`=1 in cycle 9
- Each cycle of `mem_gnt` delay or extra `mem_rvalid` delay adds one cycle to latency.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Configuration
- Macro `IMEM_CRITICAL_WORD_FIRST_EN`.
- Defined: `word_idx` starts at `first_idx`, so the missed word is fetched first, then the rest wrap around (e.g. 2,3,0,1).
- Undefined: `word_idx` starts at 0 and order is always 0,1,2,3; `first_idx` is not latched.
- Either way, each word lands in its own slot, so the final line content is identical. Only the `mem_addr` order differs.

## Test plan
1. **Reset:** hold `reset`=0 for 3 cycles with `imem_read_start`=1 → `mem_req`=0, `imem_read_rdy`=0, `imemory_data_bus1`=0; no fill starts.
2. **Basic fill, macro off:**
   - Stimulus: addr 0x0000_1008; memory returns addr^0xA5A5_0000; `mem_gnt` immediate; rvalid after 1 cycle.
   - Required: `mem_addr` sequence 0x1000, 0x1004, 0x1008, 0x100C.
   - Required: `imem_read_rdy` in cycle 9, for exactly one cycle.
   - Required: line = {0xA5A5100C, 0xA5A51008, 0xA5A51004, 0xA5A51000}.
3. **Macro on, same stimulus:** `mem_addr` sequence 0x1008, 0x100C, 0x1000, 0x1004; identical line; rdy in cycle 9.
4. **Backpressure:** delay `mem_gnt` by 3 cycles on beat 1 → `mem_req`/`mem_addr` stay at 0x1004 throughout the delay; rdy in cycle 12.
5. **Reset mid-fill:**
   - Stimulus: assert `reset`=0 after beat 2 is accepted, then release.
   - Required: IDLE next cycle; `mem_req`=0; a stray `mem_rvalid` is ignored.
   - Required: a new fill at 0x0000_2000 returns a correct line with no stale words.
6. **Protocol robustness:**
   - Stimulus: hold `imem_read_start`=1 through the fill, and inject `mem_rvalid`=1 while in REQ.
   - Required: the spurious rvalid is ignored.
   - Required: exactly 4 requests are issued.
   - Required: a second fill starts in the first IDLE cycle after DONE.
